uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, LSB first.
REQ-002 Parameter OVERSAMPLING, default 16, baud ticks per bit; even, >=8.
REQ-003 Parameter CNT_WIDTH, default $clog2(OVERSAMPLING), width of the tick counter.
REQ-004 i_clk  input  1  single clock domain for all logic.
REQ-005 i_aresetn  input  1  asynchronous, active-low reset.
REQ-006 i_baud_tick  input  1  one-cycle pulse at BAUD_RATE*OVERSAMPLING, from the baud tick generator.
REQ-007 i_rx  input  1  asynchronous serial line, idle high, 8N1 framing.
REQ-008 o_data  output  DATA_BITS  last correctly framed byte, held until the next good frame.
REQ-009 o_valid  output  1  one-cycle pulse; o_data updated in the same cycle.
REQ-010 o_frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 o_busy  output  1  high in every state except IDLE.

Function
REQ-012 i_rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; rx_s denotes its output.
REQ-013 All counter advances, state transitions and samples SHALL occur only in cycles with i_baud_tick=1; the FSM SHALL be frozen in all other cycles.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: on a tick with rx_s=0 and armed=1, go to START with tick_cnt=0; armed SHALL set on any tick with rx_s=1.
REQ-016 START: increment tick_cnt per tick; at tick_cnt=OVERSAMPLING/2-1, sample rx_s: if 1 (glitch), go to IDLE with no output pulse; if 0, clear tick_cnt, bit_cnt=0, go to DATA.
REQ-017 DATA: at tick_cnt=OVERSAMPLING-1, sample rx_s into shift register bit position bit_cnt (LSB first) and clear tick_cnt; after the sample with bit_cnt=DATA_BITS-1, go to STOP.
REQ-018 STOP: at tick_cnt=OVERSAMPLING-1, sample rx_s; go to IDLE.
REQ-019 Stop sample 1: o_data<=shift register and o_valid=1 for exactly one cycle, registered in the cycle after the sample tick.
REQ-020 Stop sample 0: o_frame_err=1 for one cycle; o_data unchanged; armed cleared, so a held-low line (break) produces exactly one frame_err and no restart until rx_s returns high.
REQ-021 o_valid and o_frame_err SHALL never be high in the same cycle.
REQ-022 tick_cnt SHALL wrap to 0 at OVERSAMPLING-1 and never exceed it; bit_cnt SHALL never exceed DATA_BITS-1.
REQ-023 A start edge arriving in the STOP tick that returns to IDLE SHALL be detected on the next tick (back-to-back frames supported).

Reset
REQ-024 On i_aresetn=0, immediately: state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0, o_data=0, o_valid=0, o_frame_err=0, o_busy=0, synchronizer flops=1, armed=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no o_valid or o_frame_err pulse; reception resumes only after a tick with rx_s=1 following reset release.

Structure
REQ-026 Package uart_pkg SHALL hold the rx_state_t enum (IDLE, START, DATA, STOP) and the DATA_BITS/OVERSAMPLING defaults shared with the transmitter.
REQ-027 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff; uart_rx instantiates it once and contains no tick generator itself.

Verification
REQ-028 CLK 100 MHz, tick every 54 clocks; idle high, send 0x55 8N1 -> one o_valid pulse with o_data=0x55, no o_frame_err, o_busy low afterwards.
REQ-029 Send 0xA5 then 0x3C with zero idle between frames -> two o_valid pulses, o_data 0xA5 then 0x3C.
REQ-030 Pull i_rx low for 3 ticks then release -> no o_valid or o_frame_err, o_busy back to 0 within OVERSAMPLING/2 ticks.
REQ-031 Send 0xF0 with stop bit forced 0 and line held low 30 bit times -> exactly one o_frame_err, o_data retains previous value, next valid 0x12 frame after release received correctly.
REQ-032 Assert i_aresetn low during bit 4 of a frame -> all outputs at reset values immediately, no pulses; next frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types and default framing parameters
package uart_pkg;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_OVERSAMPLING = 16;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input, resets to idle-high
module sync_2ff (
    input  logic i_clk,
    input  logic i_aresetn,
    input  logic i_d,
    output logic o_q
);
    logic meta;
    // shift the raw input through two flops to settle metastability
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            meta <= 1'b1;
            o_q  <= 1'b1;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 UART receiver with glitch rejection and break-safe framing errors
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int OVERSAMPLING = UART_OVERSAMPLING,
    parameter int CNT_WIDTH    = $clog2(OVERSAMPLING)
) (
    input  logic                 i_clk,
    input  logic                 i_aresetn,
    input  logic                 i_baud_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);
    localparam int BIT_W = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_WIDTH-1:0] TICK_LAST = CNT_WIDTH'(OVERSAMPLING - 1);
    localparam logic [CNT_WIDTH-1:0] TICK_MID  = CNT_WIDTH'(OVERSAMPLING / 2 - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(DATA_BITS - 1);

    rx_state_t state, state_n;
    logic [CNT_WIDTH-1:0] tick_cnt, tick_cnt_n;
    logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
    logic armed, armed_n, valid_n, ferr_n, rx_s;

    sync_2ff u_sync (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .i_d       (i_rx),
        .o_q       (rx_s)
    );

    assign o_busy = (state != IDLE);

    // next-state and datapath decisions, evaluated only on baud ticks
    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        armed_n    = armed;
        data_n     = o_data;
        valid_n    = 1'b0;
        ferr_n     = 1'b0;
        if (i_baud_tick) begin
            if (rx_s) armed_n = 1'b1;
            case (state)
                IDLE: begin
                    if (!rx_s && armed) begin
                        state_n    = START;
                        tick_cnt_n = '0;
                    end
                end
                START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_cnt_n = '0;
                        bit_cnt_n  = '0;
                        state_n    = rx_s ? IDLE : DATA;
                    end else tick_cnt_n = tick_cnt + 1'b1;
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n       = '0;
                        shreg_n[bit_cnt] = rx_s;
                        if (bit_cnt == BIT_LAST) state_n = STOP;
                        else bit_cnt_n = bit_cnt + 1'b1;
                    end else tick_cnt_n = tick_cnt + 1'b1;
                end
                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_n = '0;
                        state_n    = IDLE;
                        valid_n    = rx_s;
                        ferr_n     = !rx_s;
                        if (rx_s) data_n = shreg;
                        else armed_n = 1'b0;
                    end else tick_cnt_n = tick_cnt + 1'b1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // state, counters, shift register and registered output pulses
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            armed       <= 1'b0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            armed       <= armed_n;
            o_data      <= data_n;
            o_valid     <= valid_n;
            o_frame_err <= ferr_n;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 100 MHz with a tick every 54 clocks
module tb_uart_rx;
    localparam int TICK_DIV = 54;
    localparam int OS       = 16;
    localparam int BIT_CLKS = TICK_DIV * OS;

    logic       i_clk = 1'b0;
    logic       i_aresetn = 1'b0;
    logic       i_baud_tick = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_busy;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int div_cnt = 0;
    logic [7:0] rx_q[$];

    uart_rx dut (
        .i_clk       (i_clk),
        .i_aresetn   (i_aresetn),
        .i_baud_tick (i_baud_tick),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // free-running baud tick generator, one pulse every TICK_DIV clocks
    always @(posedge i_clk) begin
        div_cnt     <= (div_cnt == TICK_DIV - 1) ? 0 : div_cnt + 1;
        i_baud_tick <= (div_cnt == TICK_DIV - 1);
    end

    // pulse monitor sampled on the falling edge
    always @(negedge i_clk) begin
        if (o_valid) begin
            valid_cnt++;
            rx_q.push_back(o_data);
        end
        if (o_frame_err) ferr_cnt++;
        if (o_valid && o_frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input int clks);
        i_rx = b;
        repeat (clks) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive(d[i], BIT_CLKS);
        drive(stop, BIT_CLKS);
    endtask

    initial begin
        logic [7:0] d81;
        d81 = 8'h81;
        repeat (5) @(negedge i_clk);
        check("reset_data", 32'(o_data), 32'h00);
        check("reset_valid", 32'(o_valid), 32'h0);
        check("reset_ferr", 32'(o_frame_err), 32'h0);
        check("reset_busy", 32'(o_busy), 32'h0);
        i_aresetn = 1'b1;
        drive(1'b1, BIT_CLKS);

        send_frame(8'h55, 1'b1);
        check("f55_valid_cnt", 32'(valid_cnt), 32'd1);
        check("f55_data", 32'(o_data), 32'h55);
        check("f55_ferr_cnt", 32'(ferr_cnt), 32'd0);
        check("f55_busy", 32'(o_busy), 32'h0);

        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        check("b2b_valid_cnt", 32'(valid_cnt), 32'd3);
        check("b2b_first", 32'(rx_q[1]), 32'hA5);
        check("b2b_second", 32'(rx_q[2]), 32'h3C);
        check("b2b_data", 32'(o_data), 32'h3C);

        drive(1'b0, 2 * TICK_DIV + 10);
        check("glitch_busy_high", 32'(o_busy), 32'h1);
        drive(1'b0, TICK_DIV - 10);
        drive(1'b1, OS / 2 * TICK_DIV + 4);
        check("glitch_busy_low", 32'(o_busy), 32'h0);
        check("glitch_valid_cnt", 32'(valid_cnt), 32'd3);
        check("glitch_ferr_cnt", 32'(ferr_cnt), 32'd0);

        send_frame(8'hF0, 1'b0);
        drive(1'b0, 29 * BIT_CLKS);
        check("break_ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("break_valid_cnt", 32'(valid_cnt), 32'd3);
        check("break_data_kept", 32'(o_data), 32'h3C);
        check("break_busy", 32'(o_busy), 32'h0);
        drive(1'b1, BIT_CLKS);
        send_frame(8'h12, 1'b1);
        check("after_break_valid_cnt", 32'(valid_cnt), 32'd4);
        check("after_break_data", 32'(o_data), 32'h12);
        check("after_break_ferr_cnt", 32'(ferr_cnt), 32'd1);

        drive(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive(d81[i], BIT_CLKS);
        drive(d81[4], BIT_CLKS / 2);
        check("pre_reset_busy", 32'(o_busy), 32'h1);
        i_aresetn = 1'b0;
        #1;
        check("midrst_data", 32'(o_data), 32'h00);
        check("midrst_valid", 32'(o_valid), 32'h0);
        check("midrst_ferr", 32'(o_frame_err), 32'h0);
        check("midrst_busy", 32'(o_busy), 32'h0);
        i_rx = 1'b1;
        repeat (4) @(negedge i_clk);
        i_aresetn = 1'b1;
        drive(1'b1, BIT_CLKS);
        check("postrst_valid_cnt", 32'(valid_cnt), 32'd4);
        check("postrst_ferr_cnt", 32'(ferr_cnt), 32'd1);
        send_frame(8'h81, 1'b1);
        check("f81_valid_cnt", 32'(valid_cnt), 32'd5);
        check("f81_data", 32'(o_data), 32'h81);
        check("f81_logged", 32'(rx_q[4]), 32'h81);
        check("f81_busy", 32'(o_busy), 32'h0);
        check("never_both", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
